// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg: shared constants for the button-driven character buffer
package char_buffer_pkg;
  localparam int NUM_SLOTS  = 4;
  localparam int DEF_CODE_W = 2;
  localparam logic [DEF_CODE_W-1:0] GLYPH_M = 2'd0;
  localparam logic [DEF_CODE_W-1:0] GLYPH_U = 2'd1;
  localparam logic [DEF_CODE_W-1:0] GLYPH_S = 2'd2;
  localparam logic [DEF_CODE_W-1:0] GLYPH_T = 2'd3;
  localparam logic [NUM_SLOTS*DEF_CODE_W-1:0] RESET_SLOTS = {GLYPH_T, GLYPH_S, GLYPH_U, GLYPH_M};
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_INC   = 2;
  localparam int BTN_DEC   = 3;
  typedef enum logic [2:0] {ACT_NONE, ACT_LEFT, ACT_RIGHT, ACT_INC, ACT_DEC} action_e;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer plus stable-time counter producing a clean level
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl: debounced button editing of a shadow glyph buffer, committed on frame start
module char_buffer_ctrl import char_buffer_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_FRAMES    = 30,
  parameter int CODE_W          = DEF_CODE_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        B2,
  input  logic                        B3,
  input  logic                        B4,
  input  logic                        B5,
  input  logic                        frame_start,
  output logic [NUM_SLOTS*CODE_W-1:0] slot_codes,
  output logic [1:0]                  cursor,
  output logic                        cursor_blink,
  output logic                        dirty,
  output logic [3:0]                  led
);
  localparam int SW = NUM_SLOTS * CODE_W;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  function automatic logic [SW-1:0] init_slots();
    for (int i = 0; i < NUM_SLOTS; i++) init_slots[i*CODE_W +: CODE_W] = CODE_W'(i);
  endfunction
  localparam logic [SW-1:0] RST_SLOTS = CODE_W == DEF_CODE_W ? SW'(RESET_SLOTS) : init_slots();
  logic [3:0]        raw, lvl, lvl_q, press;
  logic [SW-1:0]     sh_slots, sh_slots_n;
  logic [1:0]        sh_cur, sh_cur_n;
  logic [CODE_W-1:0] sel;
  logic [FW-1:0]     frame_cnt, frame_cnt_n;
  logic              dirty_n, blink_n, wrap;
  action_e           act;
  assign raw = {B5, B4, B3, B2};
  assign led = lvl;
  genvar i;
  for (i = 0; i < 4; i++) begin : gen_db
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(raw[i]), .level(lvl[i])
    );
  end
  always_comb begin
    press = lvl & ~lvl_q;
    act = press[BTN_LEFT]  ? ACT_LEFT  :
          press[BTN_RIGHT] ? ACT_RIGHT :
          press[BTN_INC]   ? ACT_INC   :
          press[BTN_DEC]   ? ACT_DEC   : ACT_NONE;
    sel = sh_slots[sh_cur*CODE_W +: CODE_W];
    sh_cur_n = act == ACT_LEFT  ? sh_cur - 2'd1 :
               act == ACT_RIGHT ? sh_cur + 2'd1 : sh_cur;
    sh_slots_n = sh_slots;
    sh_slots_n[sh_cur*CODE_W +: CODE_W] = act == ACT_INC ? sel + CODE_W'(1) :
                                          act == ACT_DEC ? sel - CODE_W'(1) : sel;
    // an edit landing on the commit edge keeps dirty set so it is shown next frame
    dirty_n = act != ACT_NONE || (dirty && !frame_start);
    wrap = frame_start && frame_cnt == FW'(BLINK_FRAMES - 1);
    frame_cnt_n = !frame_start ? frame_cnt : wrap ? '0 : frame_cnt + 1'b1;
    blink_n = cursor_blink ^ wrap;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lvl_q        <= '0;
      sh_slots     <= RST_SLOTS;
      sh_cur       <= '0;
      slot_codes   <= RST_SLOTS;
      cursor       <= '0;
      dirty        <= 1'b0;
      frame_cnt    <= '0;
      cursor_blink <= 1'b0;
    end else begin
      lvl_q        <= lvl;
      sh_slots     <= sh_slots_n;
      sh_cur       <= sh_cur_n;
      dirty        <= dirty_n;
      frame_cnt    <= frame_cnt_n;
      cursor_blink <= blink_n;
      if (frame_start) begin
        slot_codes <= sh_slots;
        cursor     <= sh_cur;
      end
    end
endmodule

// File: tb/tb_char_buffer_ctrl.sv
// tb_char_buffer_ctrl: directed self-checking bench for char_buffer_ctrl
module tb_char_buffer_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn = '0;
  logic       frame_start = 1'b0;
  logic [7:0] slot_codes;
  logic [1:0] cursor;
  logic       cursor_blink, dirty;
  logic [3:0] led;
  int tests = 0;
  int failed = 0;

  char_buffer_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_FRAMES(2), .CODE_W(2)) dut (
    .clk(clk), .reset(reset),
    .B2(btn[0]), .B3(btn[1]), .B4(btn[2]), .B5(btn[3]),
    .frame_start(frame_start),
    .slot_codes(slot_codes), .cursor(cursor), .cursor_blink(cursor_blink),
    .dirty(dirty), .led(led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic press_btn(input logic [3:0] m);
    btn = m;
    tick(7);
    btn = '0;
    tick(8);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(2);
    chk("rst_hold_slots", slot_codes, 8'b11_10_01_00);
    reset = 1'b0;
    tick(1);
    chk("rst_slots", slot_codes, 8'b11_10_01_00);
    chk("rst_cursor", {6'd0, cursor}, 8'd0);
    chk("rst_dirty", {7'd0, dirty}, 8'd0);
    chk("rst_led", {4'd0, led}, 8'd0);
    chk("rst_blink", {7'd0, cursor_blink}, 8'd0);

    for (int k = 0; k < 10; k++) begin
      btn[2] = ~btn[2];
      tick(2);
    end
    tick(3);
    chk("bounce_led", {4'd0, led}, 8'd0);
    chk("bounce_dirty", {7'd0, dirty}, 8'd0);

    btn[2] = 1'b1;
    tick(5);
    chk("deb_led_5", {4'd0, led}, 8'd0);
    tick(1);
    chk("deb_led_6", {4'd0, led}, 8'b0000_0100);
    chk("deb_dirty_pre", {7'd0, dirty}, 8'd0);
    tick(1);
    chk("deb_dirty_post", {7'd0, dirty}, 8'd1);
    btn[2] = 1'b0;
    tick(8);
    chk("commit_pre_slots", slot_codes, 8'b11_10_01_00);
    frame();
    chk("commit_slots", slot_codes, 8'b11_10_01_01);
    chk("commit_dirty", {7'd0, dirty}, 8'd0);
    chk("commit_blink", {7'd0, cursor_blink}, 8'd0);

    press_btn(4'b0001);
    chk("left_pre_cursor", {6'd0, cursor}, 8'd0);
    chk("left_dirty", {7'd0, dirty}, 8'd1);
    frame();
    chk("left_cursor", {6'd0, cursor}, 8'd3);
    chk("left_blink", {7'd0, cursor_blink}, 8'd1);
    press_btn(4'b0100);
    frame();
    chk("inc_wrap_slots", slot_codes, 8'b00_10_01_01);

    press_btn(4'b1010);
    frame();
    chk("simul_cursor", {6'd0, cursor}, 8'd0);
    chk("simul_slots", slot_codes, 8'b00_10_01_01);
    chk("simul_blink", {7'd0, cursor_blink}, 8'd0);

    press_btn(4'b0100);
    btn[2] = 1'b1;
    tick(6);
    frame();
    chk("coinc_slots", slot_codes, 8'b00_10_01_10);
    chk("coinc_dirty", {7'd0, dirty}, 8'd1);
    btn[2] = 1'b0;
    tick(8);
    chk("coinc_hold_slots", slot_codes, 8'b00_10_01_10);
    frame();
    chk("coinc_next_slots", slot_codes, 8'b00_10_01_11);
    chk("coinc_next_dirty", {7'd0, dirty}, 8'd0);

    do_reset();
    chk("rst2_slots", slot_codes, 8'b11_10_01_00);
    frame();
    chk("blink_f1", {7'd0, cursor_blink}, 8'd0);
    frame();
    chk("blink_f2", {7'd0, cursor_blink}, 8'd1);
    frame();
    chk("blink_f3", {7'd0, cursor_blink}, 8'd1);
    tick(5);
    chk("blink_hold", {7'd0, cursor_blink}, 8'd1);
    frame();
    chk("blink_f4", {7'd0, cursor_blink}, 8'd0);

    press_btn(4'b0010);
    frame();
    chk("pre_rst_cursor", {6'd0, cursor}, 8'd1);
    press_btn(4'b0100);
    btn[2] = 1'b1;
    tick(6);
    chk("pre_rst_led", {4'd0, led}, 8'b0000_0100);
    reset = 1'b1;
    #1;
    chk("mid_rst_slots", slot_codes, 8'b11_10_01_00);
    chk("mid_rst_cursor", {6'd0, cursor}, 8'd0);
    chk("mid_rst_dirty", {7'd0, dirty}, 8'd0);
    chk("mid_rst_led", {4'd0, led}, 8'd0);
    tick(1);
    reset = 1'b0;
    tick(5);
    chk("post_rst_led_5", {4'd0, led}, 8'd0);
    chk("post_rst_dirty_5", {7'd0, dirty}, 8'd0);
    tick(1);
    chk("post_rst_led_6", {4'd0, led}, 8'b0000_0100);
    tick(1);
    chk("post_rst_dirty", {7'd0, dirty}, 8'd1);
    btn = '0;
    tick(8);
    frame();
    chk("post_rst_slots", slot_codes, 8'b11_10_01_01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
